// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-serial RAM/IO responder behind the core's memory
// controller. Low addresses hit a byte RAM; the IO window holds a UART
// TX FIFO, an optional RX FIFO and a sticky simulation-halt flag.
// Optional feature macro: MEM_IO_RX_EN (compiles in the RX FIFO).
module mem_io_responder #(
  parameter int          ADDR_WIDTH = 17,
  parameter logic [31:0] IO_BASE    = 32'h0003_0000,
  parameter int          TX_DEPTH   = 8,
  parameter int          RX_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        sim_halt
);

  localparam int          TX_AW     = $clog2(TX_DEPTH);
  localparam logic [31:0] HALT_ADDR = IO_BASE + 32'd4;
  localparam logic [TX_AW:0] TX_FULL = (TX_AW + 1)'(TX_DEPTH);

  // ---------------------------------------------------------------- decode
  logic                  is_ram;
  logic                  is_uart;
  logic                  is_halt;
  logic [ADDR_WIDTH-1:0] ram_idx;

  assign is_ram  = (mem_a < IO_BASE);
  assign is_uart = (mem_a == IO_BASE);
  assign is_halt = (mem_a == HALT_ADDR);
  assign ram_idx = mem_a[ADDR_WIDTH-1:0];

  // ------------------------------------------------------------------- RAM
  logic [7:0] ram [0:(2**ADDR_WIDTH)-1];

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (mem_wr && is_ram) begin
      ram[ram_idx] <= mem_dout;
    end
  end

  // --------------------------------------------------------------- TX FIFO
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr;
  logic [TX_AW-1:0] tx_rd_ptr;
  logic [TX_AW:0]   tx_count;
  logic [TX_AW:0]   tx_count_nxt;
  logic             tx_push;
  logic             tx_pop;

  assign io_buffer_full = (tx_count == TX_FULL);
  assign tx_valid       = (tx_count != '0);
  assign tx_push        = mem_wr && is_uart && !io_buffer_full;
  assign tx_pop         = tx_valid && tx_ready;
  // Storage is not cleared on reset, so mask the head while empty
  assign tx_data        = tx_valid ? tx_mem[tx_rd_ptr] : 8'h00;

  // TX occupancy: a simultaneous push and pop leaves the count unchanged
  always_comb begin
    tx_count_nxt = tx_count;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_nxt = tx_count + (TX_AW + 1)'(1);
      2'b01:   tx_count_nxt = tx_count - (TX_AW + 1)'(1);
      default: tx_count_nxt = tx_count;
    endcase
  end

  // TX pointers and count; pointers wrap naturally (depth is a power of two)
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) begin
        tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      end
      if (tx_pop) begin
        tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      end
      tx_count <= tx_count_nxt;
    end
  end

  // TX storage write
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= mem_dout;
    end
  end

  // --------------------------------------------------------------- RX FIFO
  logic [7:0] rx_rd_data;

`ifdef MEM_IO_RX_EN
  localparam int             RX_AW   = $clog2(RX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL = (RX_AW + 1)'(RX_DEPTH);

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr;
  logic [RX_AW-1:0] rx_rd_ptr;
  logic [RX_AW:0]   rx_count;
  logic [RX_AW:0]   rx_count_nxt;
  logic             rx_push;
  logic             rx_pop;
  logic             rx_empty;

  assign rx_empty   = (rx_count == '0);
  assign rx_ready   = (rx_count != RX_FULL);
  assign rx_push    = rx_valid && rx_ready;
  assign rx_pop     = !mem_wr && is_uart && !rx_empty;
  // An empty FIFO reads as zero even if a byte is arriving this cycle
  assign rx_rd_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

  // RX occupancy
  always_comb begin
    rx_count_nxt = rx_count;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_nxt = rx_count + (RX_AW + 1)'(1);
      2'b01:   rx_count_nxt = rx_count - (RX_AW + 1)'(1);
      default: rx_count_nxt = rx_count;
    endcase
  end

  // RX pointers and count
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      end
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      end
      rx_count <= rx_count_nxt;
    end
  end

  // RX storage write
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= rx_data;
    end
  end
`else
  logic unused_rx;

  assign rx_ready   = 1'b0;
  assign rx_rd_data = 8'h00;
  assign unused_rx  = ^{rx_data, rx_valid};
`endif

  // ------------------------------------------------------------ read path
  logic [7:0] din_nxt;

  // Read mux: RAM for low addresses, RX head for UART reads, zero otherwise
  always_comb begin
    din_nxt = 8'h00;
    if (is_ram) begin
      din_nxt = ram[ram_idx];
    end else if (is_uart && !mem_wr) begin
      din_nxt = rx_rd_data;
    end else begin
      din_nxt = 8'h00;
    end
  end

  // Registered read data, one cycle after the address
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_din <= 8'h00;
    end else begin
      mem_din <= din_nxt;
    end
  end

  // Sticky halt request, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sim_halt <= 1'b0;
    end else if (mem_wr && is_halt) begin
      sim_halt <= 1'b1;
    end else begin
      sim_halt <= sim_halt;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: stimulus pushes expected values,
// a monitor pops and compares them just after each rising edge.
module tb_mem_io_responder;

  logic        clk;
  logic        rst;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        sim_halt;

  // values applied by step() at the next falling edge
  logic        drv_rst;
  logic        drv_tx_ready;
  logic        drv_rx_valid;
  logic [7:0]  drv_rx_data;

  localparam int K_DIN   = 0;
  localparam int K_FULL  = 1;
  localparam int K_TXV   = 2;
  localparam int K_TXD   = 3;
  localparam int K_RXR   = 4;
  localparam int K_HALT  = 5;

  int         q_kind[$];
  logic [7:0] q_exp[$];
  string      q_name[$];

  int n_checks = 0;
  int n_pass   = 0;

  mem_io_responder dut (
    .clk            (clk),
    .rst            (rst),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .sim_halt       (sim_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] actual(input int kind);
    case (kind)
      K_DIN:   return mem_din;
      K_FULL:  return {7'd0, io_buffer_full};
      K_TXV:   return {7'd0, tx_valid};
      K_TXD:   return tx_data;
      K_RXR:   return {7'd0, rx_ready};
      K_HALT:  return {7'd0, sim_halt};
      default: return 8'hXX;
    endcase
  endfunction

  // monitor: after each edge, compare every expectation queued for it
  always @(posedge clk) begin
    #1;
    while (q_kind.size() > 0) begin
      int         k;
      logic [7:0] e;
      logic [7:0] a;
      string      nm;
      k  = q_kind.pop_front();
      e  = q_exp.pop_front();
      nm = q_name.pop_front();
      a  = actual(k);
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %02h expected %02h", nm, a, e);
    end
  end

  task automatic step(input logic [31:0] a, input logic [7:0] d, input logic wr);
    @(negedge clk);
    mem_a    = a;
    mem_dout = d;
    mem_wr   = wr;
    rst      = drv_rst;
    tx_ready = drv_tx_ready;
    rx_valid = drv_rx_valid;
    rx_data  = drv_rx_data;
  endtask

  task automatic expect_val(input int kind, input logic [7:0] e, input string nm);
    q_kind.push_back(kind);
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask

  logic [7:0] word_bytes [4] = '{8'h44, 8'h33, 8'h22, 8'h11};

  initial begin
    rst = 1'b1; mem_a = 32'd0; mem_dout = 8'd0; mem_wr = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    drv_rst = 1'b1; drv_tx_ready = 1'b0; drv_rx_valid = 1'b0; drv_rx_data = 8'd0;

    // reset state
    step(32'd0, 8'd0, 1'b0);
    step(32'd0, 8'd0, 1'b0);
    expect_val(K_DIN,  8'h00, "reset_din");
    expect_val(K_FULL, 8'h00, "reset_full");
    expect_val(K_TXV,  8'h00, "reset_tx_valid");
    expect_val(K_TXD,  8'h00, "reset_tx_data");
`ifdef MEM_IO_RX_EN
    expect_val(K_RXR,  8'h01, "reset_rx_ready");
`else
    expect_val(K_RXR,  8'h00, "reset_rx_ready");
`endif
    expect_val(K_HALT, 8'h00, "reset_halt");
    drv_rst = 1'b0;

    // RAM round trip
    step(32'h0000_0104, 8'hA5, 1'b1);
    step(32'h0000_0104, 8'h00, 1'b0);
    expect_val(K_DIN, 8'hA5, "ram_rd_104");
    step(32'h0000_0105, 8'h3C, 1'b1);
    step(32'h0000_0104, 8'h00, 1'b0);
    expect_val(K_DIN, 8'hA5, "ram_rd_104_after_105");
    step(32'h0000_0105, 8'h00, 1'b0);
    expect_val(K_DIN, 8'h3C, "ram_rd_105");

    // word store, byte by byte, then read back
    for (int i = 0; i < 4; i++) step(32'h200 + 32'(i), word_bytes[i], 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(32'h200 + 32'(i), 8'h00, 1'b0);
      expect_val(K_DIN, word_bytes[i], $sformatf("word_rd_%0d", i));
    end

    // TX back-pressure with tx_ready low
    drv_tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(32'h0003_0000, 8'(i), 1'b1);
      if (i == 7) expect_val(K_FULL, 8'h00, "tx_not_full_at_7");
    end
    expect_val(K_FULL, 8'h01, "tx_full_at_8");
    expect_val(K_TXD,  8'h01, "tx_head_1");
    step(32'h0003_0000, 8'd9, 1'b1);
    expect_val(K_FULL, 8'h01, "tx_9th_blocked_full");
    expect_val(K_TXD,  8'h01, "tx_9th_blocked_head");
    drv_tx_ready = 1'b1;
    step(32'h0003_0000, 8'd9, 1'b1);
    expect_val(K_FULL, 8'h00, "tx_full_drops");
    expect_val(K_TXD,  8'h02, "tx_head_after_pop");
    drv_tx_ready = 1'b0;
    step(32'h0003_0000, 8'd9, 1'b1);
    expect_val(K_FULL, 8'h01, "tx_9th_enqueued");
    drv_tx_ready = 1'b1;
    for (int v = 3; v <= 9; v++) begin
      step(32'd0, 8'd0, 1'b0);
      expect_val(K_TXD, 8'(v), $sformatf("tx_drain_%0d", v));
    end
    step(32'd0, 8'd0, 1'b0);
    expect_val(K_TXV, 8'h00, "tx_empty_valid");
    expect_val(K_TXD, 8'h00, "tx_empty_data");
    drv_tx_ready = 1'b0;

`ifdef MEM_IO_RX_EN
    // RX FIFO
    drv_rx_valid = 1'b1; drv_rx_data = 8'h41;
    step(32'd0, 8'd0, 1'b0);
    drv_rx_data = 8'h42;
    step(32'd0, 8'd0, 1'b0);
    drv_rx_valid = 1'b0;
    step(32'h0003_0000, 8'd0, 1'b0);
    expect_val(K_DIN, 8'h41, "rx_rd_41");
    step(32'h0003_0000, 8'd0, 1'b0);
    expect_val(K_DIN, 8'h42, "rx_rd_42");
    step(32'h0003_0000, 8'd0, 1'b0);
    expect_val(K_DIN, 8'h00, "rx_rd_empty");
    drv_rx_valid = 1'b1; drv_rx_data = 8'h55;
    step(32'h0003_0000, 8'd0, 1'b0);
    expect_val(K_DIN, 8'h00, "rx_rd_coincident_push");
    drv_rx_valid = 1'b0;
    step(32'h0003_0000, 8'd0, 1'b0);
    expect_val(K_DIN, 8'h55, "rx_rd_55");
    drv_rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drv_rx_data = 8'h60 + 8'(i);
      step(32'd0, 8'd0, 1'b0);
      if (i == 6) expect_val(K_RXR, 8'h01, "rx_ready_at_7");
    end
    expect_val(K_RXR, 8'h00, "rx_ready_full");
    drv_rx_data = 8'h77;
    step(32'h0003_0000, 8'd0, 1'b0);
    expect_val(K_DIN, 8'h60, "rx_rd_full_head");
    expect_val(K_RXR, 8'h01, "rx_ready_after_pop");
    drv_rx_valid = 1'b0;
    step(32'h0003_0000, 8'd0, 1'b0);
    expect_val(K_DIN, 8'h61, "rx_rd_second");
`else
    drv_rx_valid = 1'b1; drv_rx_data = 8'h41;
    step(32'h0003_0000, 8'd0, 1'b0);
    expect_val(K_DIN, 8'h00, "rx_disabled_rd");
    expect_val(K_RXR, 8'h00, "rx_disabled_ready");
    drv_rx_valid = 1'b0;
    step(32'h0003_0000, 8'd0, 1'b0);
    expect_val(K_DIN, 8'h00, "rx_disabled_rd2");
`endif

    // halt and unmapped IO
    step(32'h0003_0004, 8'h7E, 1'b1);
    expect_val(K_HALT, 8'h01, "halt_set");
    step(32'h0003_0008, 8'hFF, 1'b1);
    expect_val(K_HALT, 8'h01, "halt_sticky");
    step(32'h0003_0008, 8'h00, 1'b0);
    expect_val(K_DIN,  8'h00, "unmapped_io_rd");

    // reset mid-drain
    for (int i = 0; i < 5; i++) step(32'h0003_0000, 8'hC0 + 8'(i), 1'b1);
    expect_val(K_TXV, 8'h01, "tx_valid_before_rst");
    expect_val(K_TXD, 8'hC0, "tx_head_before_rst");
    drv_rst = 1'b1;
    step(32'd0, 8'd0, 1'b0);
    expect_val(K_TXV,  8'h00, "rst_mid_tx_valid");
    expect_val(K_FULL, 8'h00, "rst_mid_full");
    expect_val(K_TXD,  8'h00, "rst_mid_tx_data");
    expect_val(K_HALT, 8'h00, "rst_mid_halt");
    drv_rst = 1'b0;
    step(32'h0000_0104, 8'd0, 1'b0);
    expect_val(K_DIN, 8'hA5, "ram_kept_104");
    step(32'h0000_0200, 8'd0, 1'b0);
    expect_val(K_DIN, 8'h44, "ram_kept_200");
    step(32'd0, 8'd0, 1'b0);
    @(negedge clk);

    if (q_kind.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q_kind.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Byte-wide memory/IO responder on the far side of the core's RAM port. Serves the byte-serial reads and writes issued by the memory controller over `mem_a`/`mem_dout`/`mem_wr`/`mem_din`:
- Backs low addresses with a synchronous byte RAM.
- Decodes the IO window into a UART transmit FIFO, an optional receive FIFO and a simulation-halt register.
- Generates `io_buffer_full` back-pressure for stores.

Sits between the memory controller and the board RAM/UART.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: RAM index width; RAM holds 2^ADDR_WIDTH bytes.
- `IO_BASE`, 32'h30000: first IO address; `IO_BASE` = UART data, `IO_BASE+4` = halt.
- `TX_DEPTH`, 8: TX FIFO entries, power of two, ≥2.
- `RX_DEPTH`, 8: RX FIFO entries, power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_a`  in  32  byte address from controller.
- `mem_dout`  in  8  write byte from controller.
- `mem_wr`  in  1  1 = write, 0 = read.
- `mem_din`  out  8  read byte to controller, one cycle after address.
- `io_buffer_full`  out  1  TX FIFO full; controller stalls stores while high.
- `tx_data`  out  8  head of TX FIFO.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_ready`  in  1  UART accepts `tx_data` this cycle.
- `rx_data`  in  8  byte from UART receiver.
- `rx_valid`  in  1  `rx_data` valid this cycle.
- `rx_ready`  out  1  RX FIFO not full.
- `sim_halt`  out  1  sticky halt request.

## Operation
- **Decode:**
  - `mem_a < IO_BASE`: RAM, index `mem_a[ADDR_WIDTH-1:0]`.
  - `mem_a == IO_BASE`: UART.
  - `mem_a == IO_BASE+4`: halt.
  - Other IO addresses: reads return 0, writes are ignored.
- **RAM write:** `mem_wr=1` to RAM writes `mem_dout` at the rising edge. Repeated identical writes while the controller stalls are harmless. RAM contents are not reset.
- **RAM read:** `mem_wr=0` registers the RAM byte into `mem_din` at the edge.
- **UART write:** enqueues `mem_dout` into the TX FIFO only when `mem_wr=1`, `mem_a==IO_BASE` and `io_buffer_full==0`. Exactly one entry per such cycle.
- **UART read:**
  - `mem_wr=0` at `IO_BASE` pops the RX FIFO head into `mem_din`.
  - If the RX FIFO is empty, `mem_din` is 0 and nothing is popped.
- **Halt:** any write to `IO_BASE+4` sets `sim_halt`. It stays set until reset.
- **TX FIFO:**
  - `tx_valid` = count≠0.
  - Pop when `tx_valid & tx_ready`.
  - Pointers wrap modulo depth; count width is clog2(depth)+1.
- **RX FIFO:** push when `rx_valid & rx_ready`; `rx_ready` = count≠RX_DEPTH.
- **`io_buffer_full`:** combinational, = (tx_count == TX_DEPTH) from the registered count.
- **Any other non-IO cycle:** `mem_din` takes the RAM byte at `mem_a`. The controller's idle address 0 makes this a benign read.

## Timing
- **Reset values:** `mem_din`=0, `io_buffer_full`=0, `tx_valid`=0, `tx_data`=0, `rx_ready`=1, `sim_halt`=0. All FIFO pointers and counts are 0.
- **Read latency:** 1 cycle. An address presented in cycle n yields `mem_din` valid in cycle n+1, and it holds until the next edge.
- **Write latency:** 0. Data is committed at the edge ending the `mem_wr` cycle. A read of the same address in the next cycle returns the new byte.
- **Simultaneous TX push and pop:**
  - With count<TX_DEPTH: both happen, count unchanged.
  - At count==TX_DEPTH: the push is blocked (full), the pop happens, and `io_buffer_full` drops the next cycle.
- **Simultaneous RX push and pop:** both happen. At RX full the push is refused via `rx_ready`=0.
- **RX empty:** a read that coincides with an RX push returns 0. The pushed byte is readable from the next cycle.
- **Reset mid-operation:** FIFOs are flushed, in-flight bytes are lost, and `sim_halt` is cleared. RAM is preserved.

## Configuration
- **`MEM_IO_RX_EN`**
  - Defined: RX FIFO and `rx_*` handling are compiled in as described.
  - Undefined: no RX storage; `rx_ready` is tied to 0, and reads of `IO_BASE` return 0 with no side effect.
- The TX path, RAM and halt are unaffected either way.

## Test plan
- **RAM round trip:** write 8'hA5 to 0x00104, then read 0x00104 → `mem_din`=8'hA5 one cycle later. Write 8'h3C to 0x00105 and check that 0x00104 still reads 8'hA5.
- **Word write:** 4-byte store 32'h11223344 at 0x200 (bytes 44,33,22,11 at consecutive cycles) → byte reads at 0x200..0x203 return 44,33,22,11.
- **TX back-pressure:** hold `tx_ready`=0 and write 9 bytes to 0x30000.
  - `io_buffer_full` rises after the 8th push; the 9th cycle is not enqueued while full.
  - Pulse `tx_ready`=1 once → head popped, `io_buffer_full` falls, the held 9th write enqueues.
  - `tx_data` then drains in order 1..9.
- **RX path (`MEM_IO_RX_EN` defined):**
  - Push 8'h41 and 8'h42 via `rx_valid`; read 0x30000 twice → 8'h41, then 8'h42.
  - A third read → 0.
  - Without the macro: first read → 0, `rx_ready`=0.
- **Halt:** write any byte to 0x30004 → `sim_halt`=1 next cycle, stays 1 until `rst` → 0.
- **Reset mid-drain:** 5 entries in TX FIFO, assert `rst` one cycle → `tx_valid`=0, `io_buffer_full`=0, and previously written RAM bytes still read back.
